// File: rtl/up_pkg.sv
// Shared types and constants for the 8-bit micro fetch path.
package up_pkg;

  localparam int UP_AW = 8;
  localparam int UP_DW = 8;
  localparam logic [UP_AW-1:0] UP_RESET_PC = 8'h00;

  typedef struct packed {
    logic [UP_AW-1:0] pc;
    logic [UP_DW-1:0] data;
  } fetch_entry_t;

  // Sequential program counter step; wraps 8'hFF -> 8'h00.
  function automatic logic [UP_AW-1:0] pc_next(input logic [UP_AW-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/up_fetch_if.sv
// Fetch-stage bus: memory port, redirect and decoder handshake.
// master = fetch stage, slave = memory / execute / decoder side.
interface up_fetch_if;
  import up_pkg::*;

  logic [UP_AW-1:0] mem_address;
  logic [UP_DW-1:0] mem_data;
  logic             mem_re;
  logic             mem_busy;
  logic             jump;
  logic [UP_AW-1:0] jump_addr;
  logic [UP_DW-1:0] instr;
  logic [UP_AW-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    output mem_address, instr, instr_pc, instr_valid,
    input  mem_data, mem_re, mem_busy, jump, jump_addr, instr_ready
  );

  modport slave (
    input  mem_address, instr, instr_pc, instr_valid,
    output mem_data, mem_re, mem_busy, jump, jump_addr, instr_ready
  );

endinterface

// File: rtl/up_fetch_fifo.sv
// Prefetch queue of {pc, data} entries. Flush beats push and pop.
module up_fetch_fifo
  import up_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_r;
  logic [PW-1:0] wr_r;
  logic [CW-1:0] count_r;

  // Queue storage, pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
    end else if (flush) begin
      rd_r    <= '0;
      wr_r    <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        mem_r[wr_r] <= wdata;
        wr_r        <= wr_r + PTR_ONE;
      end
      if (pop) rd_r <= rd_r + PTR_ONE;
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_r];
  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/up_fetch.sv
// Instruction fetch stage: program counter, jump redirect/flush and prefetch
// queue toward the decoder.
// Optional: define UP_FETCH_STALL_CNT_EN to add the stall_cnt[15:0] output
// counting cycles where the decoder is ready but nothing is queued.
module up_fetch
  import up_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [UP_AW-1:0] RESET_PC = UP_RESET_PC
) (
  input  logic        clk,
  input  logic        nRst,
  up_fetch_if.master  bus
`ifdef UP_FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [UP_AW-1:0] pc_r;
  fetch_entry_t     last_r;
  fetch_entry_t     head_s;
  fetch_entry_t     wdata_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    count_s;
  logic             valid_s;
  logic             push_s;
  logic             pop_s;

  // Jump suppresses both queue operations; a pop frees a slot for a same-cycle push.
  assign valid_s = (count_s != '0);
  assign pop_s   = !empty_s && bus.instr_ready && !bus.jump;
  assign push_s  = bus.mem_re && !bus.mem_busy && !bus.jump && (!full_s || pop_s);
  assign wdata_s = '{pc: pc_r, data: bus.mem_data};

  up_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.jump),
    .wdata (wdata_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Program counter: redirect on jump, advance only when a byte is captured.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pc_r <= RESET_PC;
    end else if (bus.jump) begin
      pc_r <= bus.jump_addr;
    end else if (push_s) begin
      pc_r <= pc_next(pc_r);
    end else begin
      pc_r <= pc_r;
    end
  end

  // Remember the last entry handed to the decoder so instr holds while empty.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last_r <= '0;
    end else if (pop_s) begin
      last_r <= head_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign bus.mem_address = pc_r;
  assign bus.instr_valid = valid_s;
  assign bus.instr       = valid_s ? head_s.data : last_r.data;
  assign bus.instr_pc    = valid_s ? head_s.pc   : last_r.pc;

`ifdef UP_FETCH_STALL_CNT_EN
  // Decoder-starved cycle counter; jump clear wins, saturates at all ones.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stall_cnt <= 16'h0000;
    end else if (bus.jump) begin
      stall_cnt <= 16'h0000;
    end else if (bus.instr_ready && !valid_s && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule
